// File: rtl/market_data_pkg.sv
// Shared types and constants for the market-data feed parsers.
// Holds the parser state encoding, legal symbol character bounds and field positions.
package market_data_pkg;

   localparam int SYM_W   = 16;
   localparam int PRICE_W = 16;
   localparam int WORD_W  = SYM_W + PRICE_W;

   localparam logic [7:0] CHAR_LO_DEF = 8'h41;
   localparam logic [7:0] CHAR_HI_DEF = 8'h5A;

   localparam int SYM_MSB   = 31;
   localparam int SYM_LSB   = 16;
   localparam int PRICE_MSB = 15;
   localparam int PRICE_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CHECK = 2'b01,
      EMIT  = 2'b10
   } state_e;

   function automatic logic char_in_range(input logic [7:0] c,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/market_data_field_check.sv
// Combinational packet validator: both symbol bytes must be legal characters
// and the price must be nonzero.
module market_data_field_check
   import market_data_pkg::*;
#(
   parameter int         SYM_W   = market_data_pkg::SYM_W,
   parameter int         PRICE_W = market_data_pkg::PRICE_W,
   parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
   parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
   input  logic [SYM_W+PRICE_W-1:0] word_i,
   output logic                     valid_o
);

   logic [SYM_W-1:0]   sym;
   logic [PRICE_W-1:0] price;
   logic               hi_ok;
   logic               lo_ok;
   logic               price_ok;

   assign sym   = word_i[SYM_W+PRICE_W-1:PRICE_W];
   assign price = word_i[PRICE_W-1:0];

   assign hi_ok    = char_in_range(sym[SYM_W-1 -: 8], CHAR_LO, CHAR_HI);
   assign lo_ok    = char_in_range(sym[7:0], CHAR_LO, CHAR_HI);
   assign price_ok = (price != '0);

   assign valid_o = hi_ok & lo_ok & price_ok;

endmodule

// File: rtl/market_data_parser.sv
// Market-data word parser: captures one word per data_valid rising edge,
// validates it and publishes symbol/price with a single-cycle output_valid pulse.
//
// state | meaning
// IDLE  | waiting for a data_valid rising edge
// CHECK | held word is being validated
// EMIT  | outputs just updated; output_valid drops here
module market_data_parser
   import market_data_pkg::*;
#(
   parameter int         SYM_W   = market_data_pkg::SYM_W,
   parameter int         PRICE_W = market_data_pkg::PRICE_W,
   parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
   parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SYM_W+PRICE_W-1:0] data_in,
   input  logic                     data_valid,
   output logic [SYM_W-1:0]         symbol,
   output logic [PRICE_W-1:0]       price,
   output logic                     output_valid
);

   localparam int W = SYM_W + PRICE_W;

   state_e               state;
   state_e               state_d;
   logic                 dv_d;
   logic [W-1:0]         hold_q;
   logic [W-1:0]         hold_d;
   logic [SYM_W-1:0]     symbol_q;
   logic [SYM_W-1:0]     symbol_d;
   logic [PRICE_W-1:0]   price_q;
   logic [PRICE_W-1:0]   price_d;
   logic                 out_valid_q;
   logic                 out_valid_d;
   logic                 pkt_start;
   logic                 field_ok;

   market_data_field_check #(
      .SYM_W   (SYM_W),
      .PRICE_W (PRICE_W),
      .CHAR_LO (CHAR_LO),
      .CHAR_HI (CHAR_HI)
   ) u_field_check (
      .word_i  (hold_q),
      .valid_o (field_ok)
   );

   // A held data_valid is one packet; only the rising edge starts a capture.
   assign pkt_start = data_valid & ~dv_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dv_d        <= 1'b0;
         hold_q      <= '0;
         symbol_q    <= '0;
         price_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_d;
         dv_d        <= data_valid;
         hold_q      <= hold_d;
         symbol_q    <= symbol_d;
         price_q     <= price_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state;
      hold_d      = hold_q;
      symbol_d    = symbol_q;
      price_d     = price_q;
      out_valid_d = 1'b0;
      case (state)
         IDLE: begin
            if (pkt_start) begin
               hold_d  = data_in;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (field_ok) begin
               symbol_d    = hold_q[W-1:PRICE_W];
               price_d     = hold_q[PRICE_W-1:0];
               out_valid_d = 1'b1;
               state_d     = EMIT;
            end else begin
               state_d = IDLE;
            end
         end
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign symbol       = symbol_q;
   assign price        = price_q;
   assign output_valid = out_valid_q;

endmodule

// File: tb/tb_market_data_parser.sv
// Directed and random stimulus for market_data_parser, checked every cycle
// against a packet-level reference model.
module tb_market_data_parser;

   logic        clk;
   logic        reset;
   logic [31:0] data_in;
   logic        data_valid;
   logic [15:0] symbol;
   logic [15:0] price;
   logic        output_valid;

   int total = 0;
   int bad   = 0;

   // reference model: expected outputs, pending publication, blocked-cycle count
   logic [15:0] exp_sym, exp_price;
   logic        exp_ov;
   logic        pend;
   logic [15:0] pend_sym, pend_price;
   int          busy;
   logic        prev_dv;
   int          pulses;

   market_data_parser dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .symbol       (symbol),
      .price        (price),
      .output_valid (output_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit word_ok(input logic [31:0] w);
      int b1, b0, p;
      b1 = (w >> 24) % 256;
      b0 = (w >> 16) % 256;
      p  = w % 65536;
      return (b1 >= 65) && (b1 <= 90) && (b0 >= 65) && (b0 <= 90) && (p != 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_sym = '0; exp_price = '0; exp_ov = 1'b0;
      pend = 1'b0; busy = 0; prev_dv = 1'b0;
   endtask

   // Apply one cycle of input, advance the model by one edge, then compare.
   task automatic step(input logic dv, input logic [31:0] d);
      bit start;
      data_valid = dv;
      data_in    = d;
      @(posedge clk);
      exp_ov = 1'b0;
      if (pend) begin
         exp_sym = pend_sym; exp_price = pend_price; exp_ov = 1'b1; pend = 1'b0;
      end
      start   = dv && !prev_dv;
      prev_dv = dv;
      if (busy > 0) busy--;
      else if (start) begin
         if (word_ok(d)) begin
            pend = 1'b1; pend_sym = d[31:16]; pend_price = d[15:0]; busy = 2;
         end else busy = 1;
      end
      #1;
      if (output_valid === 1'b1) pulses++;
      chk("output_valid", {31'b0, output_valid}, {31'b0, exp_ov});
      chk("symbol", {16'b0, symbol}, {16'b0, exp_sym});
      chk("price", {16'b0, price}, {16'b0, exp_price});
   endtask

   task automatic pkt(input logic [31:0] d, input int hold, input int gap);
      for (int i = 0; i < hold; i++) step(1'b1, d);
      for (int i = 0; i < gap; i++) step(1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] w;
      int          p0;
      pulses = 0;
      model_reset();
      data_valid = 1'b0;
      data_in    = '0;
      reset      = 1'b1;
      #20;
      chk("rst_symbol", {16'b0, symbol}, 32'h0);
      chk("rst_price", {16'b0, price}, 32'h0);
      chk("rst_ov", {31'b0, output_valid}, 32'h0);
      chk("rst_state", {30'b0, dut.state}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      step(1'b0, 32'h0);

      // basic packet
      p0 = pulses;
      step(1'b1, 32'h41424344);
      chk("basic_state_check", {30'b0, dut.state}, 32'h1);
      step(1'b1, 32'h41424344);
      chk("basic_sym", {16'b0, symbol}, 32'h4142);
      chk("basic_price", {16'b0, price}, 32'h4344);
      pkt(32'h0, 0, 3);
      chk("basic_state_idle", {30'b0, dut.state}, 32'h0);
      chk("basic_pulses", pulses - p0, 1);

      // back-to-back feed
      p0 = pulses;
      pkt(32'h58475955, 2, 2);
      pkt(32'h58548940, 2, 2);
      pkt(32'h58475540, 2, 2);
      pkt(32'h58475860, 2, 2);
      chk("b2b_pulses", pulses - p0, 4);

      // rejection: lowercase symbol, zero price
      p0 = pulses;
      pkt(32'h61624344, 2, 3);
      pkt(32'h41420000, 2, 3);
      chk("reject_pulses", pulses - p0, 0);
      chk("reject_keep_sym", {16'b0, symbol}, 32'h5847);
      chk("reject_keep_price", {16'b0, price}, 32'h5860);

      // busy drop
      p0 = pulses;
      step(1'b1, 32'h41424344);
      step(1'b0, 32'h0);
      step(1'b1, 32'h5A5A0001);
      pkt(32'h0, 0, 4);
      chk("busy_pulses", pulses - p0, 1);
      chk("busy_sym", {16'b0, symbol}, 32'h4142);

      // long hold
      p0 = pulses;
      pkt(32'h5A410001, 10, 3);
      chk("long_pulses", pulses - p0, 1);
      chk("long_sym", {16'b0, symbol}, 32'h5A41);
      chk("long_price", {16'b0, price}, 32'h0001);

      // reset while in CHECK
      step(1'b1, 32'h42434445);
      chk("mid_state_check", {30'b0, dut.state}, 32'h1);
      #2;
      reset = 1'b1;
      data_valid = 1'b0;
      #1;
      chk("mid_rst_symbol", {16'b0, symbol}, 32'h0);
      chk("mid_rst_price", {16'b0, price}, 32'h0);
      chk("mid_rst_ov", {31'b0, output_valid}, 32'h0);
      chk("mid_rst_state", {30'b0, dut.state}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      pkt(32'h0, 0, 3);

      // random traffic, including spacing below the minimum
      for (int n = 0; n < 300; n++) begin
         w[31:24] = 8'($urandom_range(8'h3F, 8'h5C));
         w[23:16] = 8'($urandom_range(8'h3F, 8'h5C));
         w[15:0]  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         pkt(w, $urandom_range(1, 4), $urandom_range(0, 3));
      end
      pkt(32'h0, 0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
